// File: rtl/pipe_sub_pkg.sv
// Shared constants and types for the byte-sliced pipelined subtractor.
package pipe_sub_pkg;

  localparam int PS_W     = 32;
  localparam int PS_SLICE = 8;

  typedef logic [PS_SLICE-1:0] slice_t;

  // Number of pipeline stages: one slice is resolved per stage.
  // w must be an integer multiple of slice.
  function automatic int calc_ns(input int w, input int slice);
    return w / slice;
  endfunction

endpackage

// File: rtl/pipe_sub_sv_if.sv
// Operand/result bundle of the pipelined subtractor, including the
// flush/stall/req/vld pipeline controls shared with the adder.
interface pipe_sub_sv_if
  import pipe_sub_pkg::*;
#(
  parameter int W = PS_W
);

  logic         flush;
  logic         stall;
  logic         req;
  logic [W-1:0] x_0;
  logic [W-1:0] x_1;
  logic [W-1:0] result;
  logic         borrow;
  logic         zero;
  logic         vld;

  modport master (
    output flush, stall, req, x_0, x_1,
    input  result, borrow, zero, vld
  );

  modport slave (
    input  flush, stall, req, x_0, x_1,
    output result, borrow, zero, vld
  );

endinterface

// File: rtl/pipe_sub_sv_byte_sub.sv
// One slice of the subtractor: {b_out, y} = {0,x_0} - {0,x_1} - b_in.
module byte_sub_sv
  import pipe_sub_pkg::*;
#(
  parameter int W = PS_SLICE
) (
  input  logic         b_in,
  input  logic [W-1:0] x_0,
  input  logic [W-1:0] x_1,
  output logic [W-1:0] y,
  output logic         b_out
);

  logic [W:0] diff;

  assign diff  = {1'b0, x_0} - {1'b0, x_1} - {{W{1'b0}}, b_in};
  assign y     = diff[W-1:0];
  assign b_out = diff[W];

endmodule

// File: rtl/pipe_sub_sv_pipe_reg.sv
// Pipeline register with active-high async reset, synchronous clear and
// load enable. Clear wins over a disabled load so a flush always empties
// the pipe even while it is stalled.
module pipe_reg_sv
  import pipe_sub_pkg::*;
#(
  parameter int WIDTH = PS_SLICE
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             clr,
  input  logic             we,
  input  logic [WIDTH-1:0] d,
  output logic [WIDTH-1:0] q
);

  logic [WIDTH-1:0] data_q;

  // Reset/clear to zero, otherwise capture d when enabled
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      data_q <= '0;
    end else if (clr) begin
      data_q <= '0;
    end else if (we) begin
      data_q <= d;
    end
  end

  assign q = data_q;

endmodule

// File: rtl/pipe_sub_sv.sv
// Byte-sliced pipelined unsigned subtractor: result = x_0 - x_1.
// Slice k is resolved in stage k using operands delayed by k registers and
// the borrow registered out of stage k-1. Lower result slices are delayed
// so every slice lines up with vld. The top stage is combinational from
// its registers, giving a latency of NS-1 cycles (NS=1 is fully
// combinational).
//
// Build option: define PIPE_SUB_SAT_EN to saturate the result to zero
// whenever the subtraction borrows (borrow is still reported).
module pipe_sub_sv
  import pipe_sub_pkg::*;
#(
  parameter int W     = PS_W,
  parameter int SLICE = PS_SLICE
) (
  input logic          clk,
  input logic          reset,
  pipe_sub_sv_if.slave bus
);

  localparam int NS = calc_ns(W, SLICE);

  logic                       we;
  logic [NS-1:0]              vld_int;
  logic [NS-1:0]              bout;
  logic [NS-1:0][SLICE-1:0]   res_w;

  assign we = !bus.stall;

  // Valid chain: vld_int[0] is the request, shifted alongside the data.
  assign vld_int[0] = bus.req;

  for (genvar k = 1; k < NS; k++) begin : g_vld
    pipe_reg_sv #(.WIDTH(1)) u_vld (
      .clk (clk),
      .rst (reset),
      .clr (bus.flush),
      .we  (we),
      .d   (vld_int[k-1]),
      .q   (vld_int[k])
    );
  end

  for (genvar k = 0; k < NS; k++) begin : g_stage
    logic [SLICE-1:0] a_chain [0:k];
    logic [SLICE-1:0] b_chain [0:k];
    logic [SLICE-1:0] r_chain [0:NS-1-k];
    logic             bin;

    assign a_chain[0] = bus.x_0[k*SLICE +: SLICE];
    assign b_chain[0] = bus.x_1[k*SLICE +: SLICE];

    // Operand slice k waits k cycles so it meets the borrow from below.
    for (genvar d = 1; d <= k; d++) begin : g_op
      pipe_reg_sv #(.WIDTH(SLICE)) u_a (
        .clk (clk),
        .rst (reset),
        .clr (bus.flush),
        .we  (we),
        .d   (a_chain[d-1]),
        .q   (a_chain[d])
      );

      pipe_reg_sv #(.WIDTH(SLICE)) u_b (
        .clk (clk),
        .rst (reset),
        .clr (bus.flush),
        .we  (we),
        .d   (b_chain[d-1]),
        .q   (b_chain[d])
      );
    end

    // Borrow-in: none for the bottom slice, registered borrow otherwise.
    if (k == 0) begin : g_bin0
      assign bin = 1'b0;
    end else begin : g_binr
      pipe_reg_sv #(.WIDTH(1)) u_bff (
        .clk (clk),
        .rst (reset),
        .clr (bus.flush),
        .we  (we),
        .d   (bout[k-1]),
        .q   (bin)
      );
    end

    byte_sub_sv #(.W(SLICE)) u_sub (
      .b_in  (bin),
      .x_0   (a_chain[k]),
      .x_1   (b_chain[k]),
      .y     (r_chain[0]),
      .b_out (bout[k])
    );

    // Result slice k rides NS-1-k registers to reach the output stage.
    for (genvar j = 1; j <= NS-1-k; j++) begin : g_res
      pipe_reg_sv #(.WIDTH(SLICE)) u_r (
        .clk (clk),
        .rst (reset),
        .clr (bus.flush),
        .we  (we),
        .d   (r_chain[j-1]),
        .q   (r_chain[j])
      );
    end

    assign res_w[k] = r_chain[NS-1-k];
  end

`ifdef PIPE_SUB_SAT_EN
  assign bus.result = bout[NS-1] ? '0 : W'(res_w);
`else
  assign bus.result = W'(res_w);
`endif

  assign bus.borrow = bout[NS-1];
  assign bus.zero   = (bus.result == '0);
  assign bus.vld    = vld_int[NS-1];

endmodule

// File: tb/tb_pipe_sub_sv.sv
// Self-checking bench for pipe_sub_sv (W=32, SLICE=8, NS=4).
// Directed scenarios check fixed constants; the random scenario checks
// against a queue model of in-flight operations.
module tb_pipe_sub_sv;
  import pipe_sub_pkg::*;

  localparam int W  = 32;
  localparam int NS = 4;

  logic clk   = 1'b0;
  logic reset = 1'b1;

  pipe_sub_sv_if #(.W(W)) bus ();

  pipe_sub_sv #(.W(W), .SLICE(8)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [W-1:0] x0;
    logic [W-1:0] x1;
    int           age;
  } op_t;

  op_t q[$];

  int n_checks = 0;
  int n_pass   = 0;

  logic         exp_vld;
  logic [W-1:0] exp_result;
  logic         exp_borrow;
  logic         exp_zero;

  function automatic void ref_sub(input logic [W-1:0] x0, input logic [W-1:0] x1,
                                  output logic [W-1:0] r, output logic b, output logic z);
    b = (x0 < x1);
    r = x0 - x1;
`ifdef PIPE_SUB_SAT_EN
    if (b) r = '0;
`endif
    z = (r == '0);
  endfunction

  function automatic void model_out();
    exp_vld    = 1'b0;
    exp_result = '0;
    exp_borrow = 1'b0;
    exp_zero   = 1'b1;
    if (q.size() > 0 && q[0].age == NS-1) begin
      exp_vld = 1'b1;
      ref_sub(q[0].x0, q[0].x1, exp_result, exp_borrow, exp_zero);
    end
  endfunction

  // One clock edge: advance the model with the inputs seen at the edge.
  task automatic tick();
    @(posedge clk);
    if (reset || bus.flush) begin
      q.delete();
    end else if (!bus.stall) begin
      foreach (q[i]) q[i].age++;
      while (q.size() > 0 && q[0].age > NS-1) void'(q.pop_front());
      if (bus.req) q.push_back('{x0: bus.x_0, x1: bus.x_1, age: 1});
    end
    #1;
    model_out();
  endtask

  function automatic logic [W-1:0] pick();
    logic [W-1:0] v;
    case ($urandom_range(0, 5))
      0:       v = '0;
      1:       v = '1;
      2:       v = 32'h8000_0000;
      3:       v = W'($urandom_range(0, 3));
      default: v = $urandom;
    endcase
    return v;
  endfunction

  task automatic idle_inputs();
    bus.req   = 1'b0;
    bus.stall = 1'b0;
    bus.flush = 1'b0;
    bus.x_0   = $urandom;
    bus.x_1   = $urandom;
  endtask

  task automatic test_reset();
    idle_inputs();
    #1;
    n_checks++; if (bus.vld !== 1'b0) $display("FAIL reset_vld: got %b want 0", bus.vld); else n_pass++;
    n_checks++; if (bus.result !== 32'h0) $display("FAIL reset_result: got %h want 00000000", bus.result); else n_pass++;
    n_checks++; if (bus.borrow !== 1'b0) $display("FAIL reset_borrow: got %b want 0", bus.borrow); else n_pass++;
    n_checks++; if (bus.zero !== 1'b1) $display("FAIL reset_zero: got %b want 1", bus.zero); else n_pass++;
    tick();
    tick();
    #2 reset = 1'b0;
    tick();
    n_checks++; if (bus.vld !== 1'b0) $display("FAIL reset_release_vld: got %b want 0", bus.vld); else n_pass++;
  endtask

  task automatic test_single();
    bus.x_0 = 32'h0000_0100;
    bus.x_1 = 32'h0000_0001;
    bus.req = 1'b1;
    for (int c = 1; c <= 6; c++) begin
      tick();
      bus.req = 1'b0;
      bus.x_0 = $urandom;
      bus.x_1 = $urandom;
      n_checks++; if (bus.vld !== (c == 3)) $display("FAIL single_vld c%0d: got %b want %b", c, bus.vld, (c == 3)); else n_pass++;
      if (c == 3) begin
        n_checks++; if (bus.result !== 32'h0000_00FF) $display("FAIL single_result: got %h want 000000ff", bus.result); else n_pass++;
        n_checks++; if (bus.borrow !== 1'b0) $display("FAIL single_borrow: got %b want 0", bus.borrow); else n_pass++;
        n_checks++; if (bus.zero !== 1'b0) $display("FAIL single_zero: got %b want 0", bus.zero); else n_pass++;
      end
    end
  endtask

  task automatic test_wrap();
    logic [W-1:0] want_r;
    logic         want_z;
`ifdef PIPE_SUB_SAT_EN
    want_r = 32'h0;
    want_z = 1'b1;
`else
    want_r = 32'hFFFF_FFFF;
    want_z = 1'b0;
`endif
    bus.x_0 = 32'h0;
    bus.x_1 = 32'h1;
    bus.req = 1'b1;
    for (int c = 1; c <= 4; c++) begin
      tick();
      bus.req = 1'b0;
      n_checks++; if (bus.vld !== (c == 3)) $display("FAIL wrap_vld c%0d: got %b want %b", c, bus.vld, (c == 3)); else n_pass++;
      if (c == 3) begin
        n_checks++; if (bus.result !== want_r) $display("FAIL wrap_result: got %h want %h", bus.result, want_r); else n_pass++;
        n_checks++; if (bus.borrow !== 1'b1) $display("FAIL wrap_borrow: got %b want 1", bus.borrow); else n_pass++;
        n_checks++; if (bus.zero !== want_z) $display("FAIL wrap_zero: got %b want %b", bus.zero, want_z); else n_pass++;
      end
    end
  endtask

  task automatic test_back_to_back();
    logic [W-1:0] a [3];
    logic [W-1:0] b [3];
    logic [W-1:0] wr [3];
    logic         wb [3];
    logic         wz [3];
    a[0] = 32'h1234_5678; b[0] = 32'h1234_5678; wr[0] = 32'h0;         wb[0] = 1'b0; wz[0] = 1'b1;
    a[1] = 32'h8000_0000; b[1] = 32'h0000_0001; wr[1] = 32'h7FFF_FFFF; wb[1] = 1'b0; wz[1] = 1'b0;
    a[2] = 32'h0000_0005; b[2] = 32'h0000_0007; wb[2] = 1'b1;
`ifdef PIPE_SUB_SAT_EN
    wr[2] = 32'h0;         wz[2] = 1'b1;
`else
    wr[2] = 32'hFFFF_FFFE; wz[2] = 1'b0;
`endif
    for (int c = 1; c <= 7; c++) begin
      if (c <= 3) begin
        bus.req = 1'b1;
        bus.x_0 = a[c-1];
        bus.x_1 = b[c-1];
      end else begin
        bus.req = 1'b0;
      end
      tick();
      n_checks++; if (bus.vld !== (c >= 3 && c <= 5)) $display("FAIL b2b_vld c%0d: got %b want %b", c, bus.vld, (c >= 3 && c <= 5)); else n_pass++;
      if (c >= 3 && c <= 5) begin
        n_checks++; if (bus.result !== wr[c-3]) $display("FAIL b2b_result op%0d: got %h want %h", c-3, bus.result, wr[c-3]); else n_pass++;
        n_checks++; if (bus.borrow !== wb[c-3]) $display("FAIL b2b_borrow op%0d: got %b want %b", c-3, bus.borrow, wb[c-3]); else n_pass++;
        n_checks++; if (bus.zero !== wz[c-3]) $display("FAIL b2b_zero op%0d: got %b want %b", c-3, bus.zero, wz[c-3]); else n_pass++;
      end
    end
  endtask

  task automatic test_stall();
    bit want_v;
    bus.x_0 = 32'hDEAD_BEEF;
    bus.x_1 = 32'h0000_BEEF;
    bus.req = 1'b1;
    for (int c = 1; c <= 7; c++) begin
      tick();
      // Stalled edges at c=3,4 (in flight) and c=6 (while vld is high);
      // junk requests offered during stall must be ignored.
      bus.stall = (c == 2 || c == 3 || c == 5);
      bus.req   = bus.stall;
      bus.x_0   = $urandom;
      bus.x_1   = $urandom;
      want_v = (c == 5 || c == 6);
      n_checks++; if (bus.vld !== want_v) $display("FAIL stall_vld c%0d: got %b want %b", c, bus.vld, want_v); else n_pass++;
      if (want_v) begin
        n_checks++; if (bus.result !== 32'hDEAD_0000) $display("FAIL stall_result c%0d: got %h want dead0000", c, bus.result); else n_pass++;
        n_checks++; if (bus.borrow !== 1'b0) $display("FAIL stall_borrow c%0d: got %b want 0", c, bus.borrow); else n_pass++;
      end
    end
    idle_inputs();
  endtask

  task automatic test_flush();
    bit want_v;
    for (int c = 1; c <= 10; c++) begin
      bus.req   = (c <= 3 || c == 7);
      bus.flush = (c == 3);
      bus.stall = (c == 3);
      bus.x_0   = (c == 7) ? 32'h0001_0000 : $urandom;
      bus.x_1   = (c == 7) ? 32'h0000_0001 : $urandom;
      tick();
      want_v = (c == 9);
      n_checks++; if (bus.vld !== want_v) $display("FAIL flush_vld c%0d: got %b want %b", c, bus.vld, want_v); else n_pass++;
      if (want_v) begin
        n_checks++; if (bus.result !== 32'h0000_FFFF) $display("FAIL flush_result: got %h want 0000ffff", bus.result); else n_pass++;
      end
    end
    idle_inputs();
  endtask

  task automatic test_reset_mid();
    bit want_v;
    bus.x_0 = 32'h0000_0009;
    bus.x_1 = 32'h0000_0002;
    bus.req = 1'b1;
    tick();
    tick();
    bus.req = 1'b0;
    #2 reset = 1'b1;
    q.delete();
    #1;
    n_checks++; if (bus.vld !== 1'b0) $display("FAIL rstmid_vld: got %b want 0", bus.vld); else n_pass++;
    n_checks++; if (bus.result !== 32'h0) $display("FAIL rstmid_result: got %h want 00000000", bus.result); else n_pass++;
    n_checks++; if (bus.zero !== 1'b1) $display("FAIL rstmid_zero: got %b want 1", bus.zero); else n_pass++;
    tick();
    #2 reset = 1'b0;
    for (int c = 1; c <= 6; c++) begin
      bus.req = (c == 3);
      tick();
      want_v = (c == 5);
      n_checks++; if (bus.vld !== want_v) $display("FAIL rstmid_after_vld c%0d: got %b want %b", c, bus.vld, want_v); else n_pass++;
      if (want_v) begin
        n_checks++; if (bus.result !== 32'h0000_0007) $display("FAIL rstmid_after_result: got %h want 00000007", bus.result); else n_pass++;
      end
    end
    idle_inputs();
  endtask

  task automatic test_random();
    model_out();
    for (int c = 0; c < 600; c++) begin
      bus.req   = ($urandom_range(0, 3) != 0);
      bus.stall = ($urandom_range(0, 4) == 0);
      bus.flush = ($urandom_range(0, 22) == 0);
      bus.x_0   = pick();
      bus.x_1   = pick();
      tick();
      n_checks++; if (bus.vld !== exp_vld) $display("FAIL rand_vld c%0d: got %b want %b", c, bus.vld, exp_vld); else n_pass++;
      if (exp_vld) begin
        n_checks++; if (bus.result !== exp_result) $display("FAIL rand_result c%0d: got %h want %h", c, bus.result, exp_result); else n_pass++;
        n_checks++; if (bus.borrow !== exp_borrow) $display("FAIL rand_borrow c%0d: got %b want %b", c, bus.borrow, exp_borrow); else n_pass++;
        n_checks++; if (bus.zero !== exp_zero) $display("FAIL rand_zero c%0d: got %b want %b", c, bus.zero, exp_zero); else n_pass++;
      end
    end
    idle_inputs();
  endtask

  initial begin
    test_reset();
    test_single();
    test_wrap();
    test_back_to_back();
    test_stall();
    test_flush();
    test_reset_mid();
    test_random();
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
